// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the 4:1 mux scan sequencer.
// Holds the FSM state encoding, channel/counter widths and the enabled-channel search.
package mux_scan_pkg;

    localparam int NUM_CH  = 4;
    localparam int CH_W    = 2;
    localparam int DWELL_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic            hit;
        logic [CH_W-1:0] idx;
    } ch_sel_t;

    // Lowest enabled channel whose index is >= from; hit=0 when none remains.
    function automatic ch_sel_t find_ch(input logic [CH_W:0] from,
                                        input logic [NUM_CH-1:0] mask);
        ch_sel_t       r;
        logic [CH_W:0] iv;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            iv = i[CH_W:0];
            if (mask[i] && (iv >= from)) begin
                r.hit = 1'b1;
                r.idx = i[CH_W-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_scan_dwell_cnt.sv
// Dwell counter for mux_scan_ctrl: counts up while enabled, flags DWELL-1 as terminal count.
// With DWELL=1 the terminal count is asserted at zero, so the count never leaves zero.
module mux_scan_dwell_cnt
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [DWELL_W-1:0] TC_VAL = DWELL_W'(DWELL - 1);

    logic [DWELL_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for the 4:1 mux: walks enabled channels, samples z after a dwell, hands off a 4-bit word.
// Optional MUX_SCAN_CONT_EN: after each handshake the scan restarts with the latched mask instead of idling.
//
// state | meaning
// IDLE  | select 00, waiting for start
// SCAN  | driving an enabled channel, counting dwell, capturing z at terminal count
// DONE  | sample_valid high, sample_data held until the consumer takes it
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  mask,
    input  logic        z,
    output logic        s0,
    output logic        s2,
    output logic        busy,
    output logic [3:0]  sample_data,
    output logic        sample_valid,
    input  logic        sample_ready
);

    state_t            state, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [NUM_CH-1:0] data_q, data_d;
    logic [NUM_CH-1:0] launch_mask;
    logic              launch;
    logic              cnt_clr;
    logic              cnt_tc;
    ch_sel_t           nxt;
    ch_sel_t           first;

    mux_scan_dwell_cnt #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (state == ST_SCAN),
        .tc    (cnt_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q   <= '0;
            mask_q <= '0;
            data_q <= '0;
        end else begin
            ch_q   <= ch_d;
            mask_q <= mask_d;
            data_q <= data_d;
        end
    end

    always_comb begin
        state_d     = state;
        ch_d        = ch_q;
        mask_d      = mask_q;
        data_d      = data_q;
        cnt_clr     = 1'b0;
        launch      = 1'b0;
        launch_mask = mask;
        nxt         = '0;
        first       = '0;

        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    launch      = 1'b1;
                    launch_mask = mask;
                end
            end
            ST_SCAN: begin
                // An empty mask still spends one SCAN cycle, so valid lands at E0+1.
                if (mask_q == '0) begin
                    state_d = ST_DONE;
                    ch_d    = '0;
                    cnt_clr = 1'b1;
                end else if (cnt_tc) begin
                    data_d[ch_q] = z;
                    nxt          = find_ch({1'b0, ch_q} + 3'd1, mask_q);
                    cnt_clr      = 1'b1;
                    if (nxt.hit) begin
                        ch_d = nxt.idx;
                    end else begin
                        ch_d    = '0;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (sample_ready) begin
`ifdef MUX_SCAN_CONT_EN
                    launch      = 1'b1;
                    launch_mask = mask_q;
`else
                    state_d     = ST_IDLE;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (launch) begin
            first   = find_ch('0, launch_mask);
            state_d = ST_SCAN;
            mask_d  = launch_mask;
            data_d  = '0;
            ch_d    = first.idx;
            cnt_clr = 1'b1;
        end
    end

    assign s0           = ch_q[0];
    assign s2           = ch_q[1];
    assign busy         = (state != ST_IDLE);
    assign sample_valid = (state == ST_DONE);
    assign sample_data  = data_q;

endmodule
